alu_issue_controller: RTL and testbench
=======================================

// Module: alu_issue_controller
// PURPOSE
//  Hardware sequencer that performs the register-file/ALU exchange in RTL: accepts one command at a time over a valid/ready handshake.
//  For each ALU command: reads two source registers, presents a 27-bit instruction to ALU, writes the result back.
//  Load commands write an immediate to a register. Sits between the command source and the RegisterFile/ALU pair.
// PARAMETERS
//  DATA_W  12  register / operand width
//  ADDR_W  3   register address width (8 registers)
//  OP_W    3   ALU opcode width; alu_instruction width = OP_W + 2*DATA_W (27)
// PORTS
//  clk              in   1       clock; all state on posedge
//  rst              in   1       synchronous reset, active-high
//  cmd_valid        in   1       command present
//  cmd_ready        out  1       controller can accept a command (high in IDLE only)
//  cmd_load         in   1       1 = load immediate, 0 = ALU op
//  cmd_op           in   OP_W    ALU opcode (ignored when cmd_load)
//  cmd_rd           in   ADDR_W  destination register
//  cmd_rs1          in   ADDR_W  source A register -> instruction[23:12]
//  cmd_rs2          in   ADDR_W  source B register -> instruction[11:0]
//  cmd_imm          in   DATA_W  immediate for load
//  readAddr1        out  ADDR_W  RegisterFile read port 1 address
//  readAddr2        out  ADDR_W  RegisterFile read port 2 address
//  readOut1         in   DATA_W  RegisterFile read data 1 (combinational from readAddr1)
//  readOut2         in   DATA_W  RegisterFile read data 2 (combinational from readAddr2)
//  writeAddr        out  ADDR_W  RegisterFile write address
//  dataIn           out  DATA_W  RegisterFile write data
//  writeEn          out  1       RegisterFile write enable (write on posedge clk)
//  instruction      out  27      ALU instruction {op, A, B}
//  ALU_output       in   DATA_W  ALU result (combinational)
//  done             out  1       one-cycle pulse in the WRITE cycle
//  busy             out  1       high whenever state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all registered outputs 0 (readAddr*, writeAddr, dataIn, writeEn, instruction, done); busy=0; cmd_ready=1 after reset.
//  Handshake: accept when cmd_valid && cmd_ready at posedge; all cmd_* fields are latched on accept; later input changes are ignored.
//  FSM:
//   IDLE  -> WRITE on accept with cmd_load=1 (result := cmd_imm)
//   IDLE  -> READ  on accept with cmd_load=0; stays IDLE otherwise.
//   READ  : readAddr1=rs1, readAddr2=rs2; at edge latch opA=readOut1, opB=readOut2 -> EXEC
//   EXEC  : instruction={op,opA,opB} (held until next command); at edge result:=ALU_output -> WRITE
//   WRITE : writeEn=1, writeAddr=rd, dataIn=result, done=1 for exactly this cycle -> IDLE
//  Latency: accept edge T; ALU op writes at edge T+3; load writes at edge T+1.
//  Throughput: one ALU op per 4 cycles; one load per 2 cycles.
//  writeEn is never high outside WRITE. No commands are accepted while busy.
//  Writeback of command N completes before READ of command N+1, so rd==rs of the next command needs no forwarding.
//  rd may equal rs1/rs2. Address 7 is valid; there is no wrap logic.
//  Widths: no truncation or extension; ALU_output is used as-is (DATA_W bits).
//  Reset mid-operation: the next state is IDLE; writeEn/done go 0 that cycle; the in-flight command is dropped with no register write.
//  Reset wins over a simultaneous cmd_valid.
// TESTING
//  1) Reset, then load R0=100 and R1=2 -> two WRITE pulses with writeAddr=0/dataIn=100 and writeAddr=1/dataIn=2; cmd_ready low one cycle each.
//  2) ALU op 001, rs1=0, rs2=1, rd=2 -> instruction={3'b001,12'd100,12'd2} in EXEC; R2 written with the ALU model value at T+3; done is a 1-cycle pulse.
//  3) cmd_valid held high with 8 queued commands -> accepted exactly every 4 cycles (ALU) or 2 cycles (load); no write outside WRITE.
//  4) Op with rd=rs1=5 (R5=12'h440), rs2=6 (R6=12'h440) followed by an op reading R5 -> the second op sees the new R5.
//  5) rst asserted in the EXEC cycle -> no writeEn; state IDLE, cmd_ready=1 next cycle; target register unchanged.
//  6) cmd fields changed while busy -> ignored; the written address/data match the latched command.

Source files
------------

// File: rtl/alu_issue_controller.sv
// -----------------------------------------------------------------------------
// alu_issue_controller
//
// Sequences one register-file / ALU exchange per accepted command.
//   ALU command : READ the two sources, EXEC by presenting {op, A, B} to the
//                 ALU, WRITE the ALU result back to rd.
//   Load command: WRITE the immediate straight to rd.
// One command is accepted at a time. cmd_ready is high only in IDLE, so a
// writeback always completes before the next command reads the register file.
// Because of this, rd == rs of the following command needs no forwarding.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   cmd_valid / cmd_ready    command handshake (accept when both are high)
//   cmd_load                 1 = load cmd_imm into cmd_rd, 0 = ALU op
//   cmd_op                   ALU opcode
//   cmd_rd                   destination register
//   cmd_rs1, cmd_rs2         source registers
//   cmd_imm                  load immediate
//   readAddr1/2, readOut1/2  register-file read ports (combinational data)
//   writeAddr, dataIn,
//   writeEn                  register-file write port (written on posedge)
//   instruction              ALU instruction {op, A, B}
//   ALU_output               ALU result (combinational)
//   done                     one-cycle pulse in the WRITE cycle
//   busy                     high whenever the controller is not IDLE
// -----------------------------------------------------------------------------
module alu_issue_controller #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 3,
  parameter int OP_W   = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_load,
  input  logic [OP_W-1:0]            cmd_op,
  input  logic [ADDR_W-1:0]          cmd_rd,
  input  logic [ADDR_W-1:0]          cmd_rs1,
  input  logic [ADDR_W-1:0]          cmd_rs2,
  input  logic [DATA_W-1:0]          cmd_imm,
  output logic [ADDR_W-1:0]          readAddr1,
  output logic [ADDR_W-1:0]          readAddr2,
  input  logic [DATA_W-1:0]          readOut1,
  input  logic [DATA_W-1:0]          readOut2,
  output logic [ADDR_W-1:0]          writeAddr,
  output logic [DATA_W-1:0]          dataIn,
  output logic                       writeEn,
  output logic [OP_W+2*DATA_W-1:0]   instruction,
  input  logic [DATA_W-1:0]          ALU_output,
  output logic                       done,
  output logic                       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t              state;
  logic [OP_W-1:0]     opQ;  // opcode latched on accept
  logic [ADDR_W-1:0]   rdQ;  // destination latched on accept

  // Handshake and status follow the state register directly, so cmd_ready is
  // already high in the first cycle after reset.
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; blocking assignments would make the result
  // depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      opQ         <= '0;
      rdQ         <= '0;
      readAddr1   <= '0;
      readAddr2   <= '0;
      writeAddr   <= '0;
      dataIn      <= '0;
      writeEn     <= 1'b0;
      instruction <= '0;
      done        <= 1'b0;
    end else begin
      // Write strobes are pulses: only the transitions into WRITE raise them.
      writeEn <= 1'b0;
      done    <= 1'b0;

      case (state)
        IDLE: begin
          // cmd_ready is high in IDLE, so cmd_valid alone means accept.
          if (cmd_valid) begin
            opQ <= cmd_op;
            rdQ <= cmd_rd;
            if (cmd_load) begin
              writeAddr <= cmd_rd;
              dataIn    <= cmd_imm;
              writeEn   <= 1'b1;
              done      <= 1'b1;
              state     <= WRITE;
            end else begin
              readAddr1 <= cmd_rs1;
              readAddr2 <= cmd_rs2;
              state     <= READ;
            end
          end
        end

        READ: begin
          // Operands are captured straight into the instruction register,
          // which then holds them until the next ALU command.
          instruction <= {opQ, readOut1, readOut2};
          state       <= EXEC;
        end

        EXEC: begin
          writeAddr <= rdQ;
          dataIn    <= ALU_output;
          writeEn   <= 1'b1;
          done      <= 1'b1;
          state     <= WRITE;
        end

        WRITE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_controller.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_controller
//
// Directed bench for alu_issue_controller. The bench supplies an 8 x 12-bit
// register file (combinational read, posedge write) and a combinational ALU
// so that complete command flows can be observed. Expected values are
// hand-computed constants.
//   ALU ops: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 A<<1, 6 A>>1, 7 pass B
// -----------------------------------------------------------------------------
module tb_alu_issue_controller;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 3;
  localparam int OP_W   = 3;
  localparam int INS_W  = OP_W + 2*DATA_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_load;
  logic [OP_W-1:0]    cmd_op;
  logic [ADDR_W-1:0]  cmd_rd;
  logic [ADDR_W-1:0]  cmd_rs1;
  logic [ADDR_W-1:0]  cmd_rs2;
  logic [DATA_W-1:0]  cmd_imm;
  logic [ADDR_W-1:0]  readAddr1;
  logic [ADDR_W-1:0]  readAddr2;
  logic [DATA_W-1:0]  readOut1;
  logic [DATA_W-1:0]  readOut2;
  logic [ADDR_W-1:0]  writeAddr;
  logic [DATA_W-1:0]  dataIn;
  logic               writeEn;
  logic [INS_W-1:0]   instruction;
  logic [DATA_W-1:0]  ALU_output;
  logic               done;
  logic               busy;

  always #5 clk = ~clk;

  alu_issue_controller #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .OP_W  (OP_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_load   (cmd_load),
    .cmd_op     (cmd_op),
    .cmd_rd     (cmd_rd),
    .cmd_rs1    (cmd_rs1),
    .cmd_rs2    (cmd_rs2),
    .cmd_imm    (cmd_imm),
    .readAddr1  (readAddr1),
    .readAddr2  (readAddr2),
    .readOut1   (readOut1),
    .readOut2   (readOut2),
    .writeAddr  (writeAddr),
    .dataIn     (dataIn),
    .writeEn    (writeEn),
    .instruction(instruction),
    .ALU_output (ALU_output),
    .done       (done),
    .busy       (busy)
  );

  // ---------------- register file and ALU models ----------------
  logic [DATA_W-1:0] rf [8];
  logic              rfInit;

  assign readOut1 = rf[readAddr1];
  assign readOut2 = rf[readAddr2];

  // The register file is cleared only by rfInit, not by rst, so a reset
  // in mid-command can be shown to leave register contents untouched.
  always @(posedge clk) begin
    if (rfInit) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (writeEn) begin
      rf[writeAddr] <= dataIn;
    end
  end

  function automatic logic [DATA_W-1:0] aluModel(input logic [INS_W-1:0] ins);
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] r;
    op = ins[INS_W-1 -: OP_W];
    a  = ins[2*DATA_W-1 -: DATA_W];
    b  = ins[DATA_W-1:0];
    case (op)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = a << 1;
      3'd6:    r = a >> 1;
      default: r = b;
    endcase
    return r;
  endfunction

  assign ALU_output = aluModel(instruction);

  // ---------------- monitors ----------------
  int cyc        = 0;
  int writes     = 0;
  int badWrites  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // A write strobe is legal only in WRITE, where done and busy are both high.
  always @(negedge clk) begin
    if (writeEn) writes <= writes + 1;
    if (writeEn && (!done || !busy)) badWrites <= badWrites + 1;
  end

  // ---------------- checking helpers ----------------
  int nCompared   = 0;
  int nMismatched = 0;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command while IDLE and return 1 time unit after the accept edge.
  task automatic issueCmd(input logic load, input logic [OP_W-1:0] op,
                          input logic [ADDR_W-1:0] rd, input logic [ADDR_W-1:0] rs1,
                          input logic [ADDR_W-1:0] rs2, input logic [DATA_W-1:0] imm);
    cmd_load  = load;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rs1   = rs1;
    cmd_rs2   = rs2;
    cmd_imm   = imm;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  typedef struct packed {
    logic               load;
    logic [OP_W-1:0]    op;
    logic [ADDR_W-1:0]  rd;
    logic [ADDR_W-1:0]  rs1;
    logic [ADDR_W-1:0]  rs2;
    logic [DATA_W-1:0]  imm;
  } cmd_t;

  cmd_t tbl [8];
  int   acceptAt [8];
  int   waitCnt;
  int   writesBefore;

  initial begin
    // ---------------- 1) reset, then two loads ----------------
    rst       = 1'b1;
    rfInit    = 1'b1;
    cmd_valid = 1'b0;
    cmd_load  = 1'b0;
    cmd_op    = '0;
    cmd_rd    = '0;
    cmd_rs1   = '0;
    cmd_rs2   = '0;
    cmd_imm   = '0;
    repeat (2) tick();

    check("reset cmd_ready",   cmd_ready,   1);
    check("reset busy",        busy,        0);
    check("reset writeEn",     writeEn,     0);
    check("reset done",        done,        0);
    check("reset instruction", instruction, 0);
    check("reset readAddr1",   readAddr1,   0);
    check("reset readAddr2",   readAddr2,   0);
    check("reset writeAddr",   writeAddr,   0);
    check("reset dataIn",      dataIn,      0);

    rst    = 1'b0;
    rfInit = 1'b0;
    tick();

    issueCmd(1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 12'd100);
    check("load0 writeEn",   writeEn,   1);
    check("load0 writeAddr", writeAddr, 0);
    check("load0 dataIn",    dataIn,    100);
    check("load0 done",      done,      1);
    check("load0 cmd_ready", cmd_ready, 0);
    check("load0 busy",      busy,      1);
    tick();
    check("load0 writeEn off", writeEn,   0);
    check("load0 done off",    done,      0);
    check("load0 ready back",  cmd_ready, 1);

    issueCmd(1'b1, 3'd0, 3'd1, 3'd0, 3'd0, 12'd2);
    check("load1 writeEn",   writeEn,   1);
    check("load1 writeAddr", writeAddr, 1);
    check("load1 dataIn",    dataIn,    2);
    check("load1 cmd_ready", cmd_ready, 0);
    tick();
    check("R0 after load", rf[0], 100);
    check("R1 after load", rf[1], 2);

    // ---------------- 2) ALU op 001 (sub): R2 = R0 - R1 ----------------
    issueCmd(1'b0, 3'd1, 3'd2, 3'd0, 3'd1, 12'd0);
    check("op READ readAddr1", readAddr1, 0);
    check("op READ readAddr2", readAddr2, 1);
    check("op READ writeEn",   writeEn,   0);
    check("op READ busy",      busy,      1);
    check("op READ cmd_ready", cmd_ready, 0);
    tick();
    check("op EXEC instruction", instruction, 27'h1064002);
    check("op EXEC writeEn",     writeEn,     0);
    check("op EXEC done",        done,        0);
    tick();
    check("op WRITE writeEn",   writeEn,   1);
    check("op WRITE writeAddr", writeAddr, 2);
    check("op WRITE dataIn",    dataIn,    98);
    check("op WRITE done",      done,      1);
    tick();
    check("op done pulse end",   done,        0);
    check("op writeEn end",      writeEn,     0);
    check("op ready back",       cmd_ready,   1);
    check("op instruction held", instruction, 27'h1064002);
    check("R2 after op",         rf[2],       98);

    // ---------------- 3) back-to-back commands, cmd_valid held ----------------
    tbl[0] = '{1'b1, 3'd0, 3'd3, 3'd0, 3'd0, 12'h0F0};
    tbl[1] = '{1'b1, 3'd0, 3'd4, 3'd0, 3'd0, 12'h00F};
    tbl[2] = '{1'b0, 3'd3, 3'd5, 3'd3, 3'd4, 12'h000};
    tbl[3] = '{1'b1, 3'd0, 3'd6, 3'd0, 3'd0, 12'h007};
    tbl[4] = '{1'b0, 3'd0, 3'd7, 3'd5, 3'd6, 12'h000};
    tbl[5] = '{1'b0, 3'd4, 3'd3, 3'd3, 3'd4, 12'h000};
    tbl[6] = '{1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 12'hFFF};
    tbl[7] = '{1'b0, 3'd0, 3'd1, 3'd0, 3'd0, 12'h000};
    writesBefore = writes;

    for (int i = 0; i < 8; i++) begin
      cmd_load  = tbl[i].load;
      cmd_op    = tbl[i].op;
      cmd_rd    = tbl[i].rd;
      cmd_rs1   = tbl[i].rs1;
      cmd_rs2   = tbl[i].rs2;
      cmd_imm   = tbl[i].imm;
      cmd_valid = 1'b1;
      waitCnt   = 0;
      while (!cmd_ready && waitCnt < 10) begin
        tick();
        waitCnt++;
      end
      check("queue accept timeout", (waitCnt < 10) ? 1 : 0, 1);
      acceptAt[i] = cyc;
      tick();
    end
    cmd_valid = 1'b0;
    repeat (4) tick();

    for (int i = 0; i < 7; i++) begin
      check($sformatf("queue gap %0d", i), acceptAt[i+1] - acceptAt[i],
            tbl[i].load ? 2 : 4);
    end
    check("queue write count", writes - writesBefore, 8);
    check("queue bad writes",  badWrites,             0);
    check("queue R5 or",       rf[5],                 12'h0FF);
    check("queue R7 add",      rf[7],                 12'h106);
    check("queue R3 xor",      rf[3],                 12'h0FF);
    check("queue R1 wrap add", rf[1],                 12'hFFE);

    // ---------------- 4) rd == rs1, next op reads the new value ----------------
    issueCmd(1'b1, 3'd0, 3'd5, 3'd0, 3'd0, 12'h440);
    tick();
    issueCmd(1'b1, 3'd0, 3'd6, 3'd0, 3'd0, 12'h440);
    tick();
    issueCmd(1'b0, 3'd0, 3'd5, 3'd5, 3'd6, 12'h000);
    repeat (3) tick();
    check("R5 self-update", rf[5], 12'h880);
    issueCmd(1'b0, 3'd1, 3'd2, 3'd5, 3'd6, 12'h000);
    tick();
    check("dep op instruction", instruction, 27'h1880440);
    tick();
    check("dep op writeAddr", writeAddr, 2);
    check("dep op dataIn",    dataIn,    12'h440);
    tick();

    // ---------------- 5) reset during EXEC ----------------
    writesBefore = writes;
    issueCmd(1'b0, 3'd0, 3'd4, 3'd5, 3'd6, 12'h000);
    tick();
    check("abort EXEC instruction", instruction, 27'h0880440);
    rst = 1'b1;
    tick();
    check("abort writeEn",   writeEn,     0);
    check("abort done",      done,        0);
    check("abort cmd_ready", cmd_ready,   1);
    check("abort busy",      busy,        0);
    check("abort instr clr", instruction, 0);
    // Reset wins over a simultaneous command.
    cmd_load  = 1'b1;
    cmd_rd    = 3'd4;
    cmd_imm   = 12'hAAA;
    cmd_valid = 1'b1;
    tick();
    check("reset vs valid busy",    busy,    0);
    check("reset vs valid writeEn", writeEn, 0);
    rst       = 1'b0;
    cmd_valid = 1'b0;
    repeat (2) tick();
    check("abort R4 unchanged", rf[4],                 12'h00F);
    check("abort no writes",    writes - writesBefore, 0);

    // ---------------- 6) command inputs changed while busy ----------------
    issueCmd(1'b0, 3'd2, 3'd6, 3'd5, 3'd3, 12'h000);
    cmd_valid = 1'b1;
    cmd_load  = 1'b1;
    cmd_op    = 3'd7;
    cmd_rd    = 3'd1;
    cmd_rs1   = 3'd0;
    cmd_rs2   = 3'd0;
    cmd_imm   = 12'hABC;
    check("busy READ readAddr1", readAddr1, 5);
    check("busy READ readAddr2", readAddr2, 3);
    tick();
    check("busy EXEC instruction", instruction, 27'h28800FF);
    tick();
    cmd_valid = 1'b0;
    check("busy WRITE writeAddr", writeAddr, 6);
    check("busy WRITE dataIn",    dataIn,    12'h080);
    tick();
    check("busy ready back", cmd_ready, 1);
    check("busy R6 written", rf[6],     12'h080);
    check("busy R1 intact",  rf[1],     12'hFFE);
    tick();
    check("busy idle stays", busy,      0);
    check("final bad writes", badWrites, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
